// File: rtl/scan_decoder_138.sv
// ---------------------------------------------------------------------------
// scan_decoder_138
//
// A registered, parametrised descendant of the '138 3-to-8 decoder. It keeps
// the G1 / G2A_ / G2B_ enable trio and the active-low one-hot output, and adds
// two ways to choose the selected line:
//   direct mode (mode=0) : the index is captured from addr whenever load=1.
//   scan mode   (mode=1) : the index steps 0..LAST by itself, dwelling DIV
//                          enabled cycles on each value; wrap pulses for one
//                          cycle on every return to 0.
// Typical use: digit/row select for a multiplexed display.
//
// Parameters
//   SEL_W : index width; there are OUT_N = 2**SEL_W outputs
//   DIV   : enabled cycles spent on each index in scan mode (1..65535)
//   LAST  : highest index visited in scan mode (0..OUT_N-1)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   G1     in   enable, active-high
//   G2A_   in   enable, active-low
//   G2B_   in   enable, active-low
//   mode   in   0 = direct, 1 = scan
//   load   in   direct mode: capture addr on this edge
//   addr   in   direct-mode index
//   Y_     out  decoded output, active-low one-hot, all ones when disabled
//   cur    out  current registered index
//   wrap   out  one-cycle pulse when the scan index returns to 0
//
// All outputs come straight from flops; Y_ reflects the index written on the
// same edge, so load/enable changes appear on Y_ one clock later.
// ---------------------------------------------------------------------------
module scan_decoder_138 #(
    parameter int SEL_W = 3,
    parameter int DIV   = 4,
    parameter int LAST  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  G1,
    input  logic                  G2A_,
    input  logic                  G2B_,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      addr,
    output logic [(2**SEL_W)-1:0] Y_,
    output logic [SEL_W-1:0]      cur,
    output logic                  wrap
);

    localparam int OUT_N = 2 ** SEL_W;

    // One extra bit over clog2(DIV) so DIV-1 always fits, even for DIV=1
    // (clog2 gives 0) and for DIV at the top of its range.
    localparam int PW = $clog2(DIV) + 1;

    localparam logic [PW-1:0]    PRE_MAX  = PW'(DIV - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);
    localparam logic [OUT_N-1:0] ONE_HOT0 = OUT_N'(1);

    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [PW-1:0]    pre_q,  pre_d;
    logic [OUT_N-1:0] y_q,    y_d;
    logic             wrap_q, wrap_d;
    logic             en;

    assign en = G1 & ~G2A_ & ~G2B_;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d  = idx_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;

        if (!mode) begin
            // Direct mode: the dwell counter stays cleared so that a later
            // switch into scan mode always starts a full dwell.
            pre_d = '0;
            if (load) begin
                idx_d = addr;
            end
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                // >= rather than == so an out-of-range index left over from
                // direct mode folds straight back to 0.
                if (idx_q >= LAST_IDX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // Decode the index being written this edge, not the old one.
        if (en) begin
            y_d = ~(ONE_HOT0 << idx_d);
        end else begin
            y_d = '1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pre_q  <= '0;
            y_q    <= '1;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign Y_   = y_q;
    assign cur  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder_138.sv
// Bench for scan_decoder_138. Three instances with different DIV/LAST share
// one set of inputs; a behavioural model (integer dwell count per instance)
// predicts every output after every edge, and directed sections add fixed
// expected values from hand-worked scenarios.
module tb_scan_decoder_138;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       G1, G2A_, G2B_, mode, load;
    logic [2:0] addr;

    logic [2:0][7:0] y_o;
    logic [2:0][2:0] cur_o;
    logic [2:0]      wrap_o;

    int n_checks = 0;
    int n_err    = 0;

    // Model configuration and state, one entry per instance.
    int p_div [3] = '{4, 1, 3};
    int p_last[3] = '{7, 5, 7};
    int m_idx [3];
    int m_cnt [3];   // enabled scan cycles spent on the current index
    bit m_wrap[3];
    bit m_en  [3];

    always #5 clk = ~clk;

    scan_decoder_138 #(.SEL_W(3), .DIV(4), .LAST(7)) u0 (
        .clk(clk), .rst_n(rst_n), .G1(G1), .G2A_(G2A_), .G2B_(G2B_),
        .mode(mode), .load(load), .addr(addr),
        .Y_(y_o[0]), .cur(cur_o[0]), .wrap(wrap_o[0])
    );

    scan_decoder_138 #(.SEL_W(3), .DIV(1), .LAST(5)) u1 (
        .clk(clk), .rst_n(rst_n), .G1(G1), .G2A_(G2A_), .G2B_(G2B_),
        .mode(mode), .load(load), .addr(addr),
        .Y_(y_o[1]), .cur(cur_o[1]), .wrap(wrap_o[1])
    );

    scan_decoder_138 #(.SEL_W(3), .DIV(3), .LAST(7)) u2 (
        .clk(clk), .rst_n(rst_n), .G1(G1), .G2A_(G2A_), .G2B_(G2B_),
        .mode(mode), .load(load), .addr(addr),
        .Y_(y_o[2]), .cur(cur_o[2]), .wrap(wrap_o[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_y(input int i);
        logic [7:0] v;
        v = 8'hFF;
        if (m_en[i]) v[m_idx[i]] = 1'b0;
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs as sampled there.
    task automatic model_edge();
        bit en;
        en = G1 && !G2A_ && !G2B_;
        for (int i = 0; i < 3; i++) begin
            m_wrap[i] = 1'b0;
            if (!rst_n) begin
                m_idx[i] = 0;
                m_cnt[i] = 0;
                m_en[i]  = 1'b0;
            end else begin
                m_en[i] = en;
                if (!mode) begin
                    m_cnt[i] = 0;
                    if (load) m_idx[i] = int'(addr);
                end else if (en) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == p_div[i]) begin
                        m_cnt[i] = 0;
                        if (m_idx[i] >= p_last[i]) begin
                            m_idx[i]  = 0;
                            m_wrap[i] = 1'b1;
                        end else begin
                            m_idx[i] = m_idx[i] + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_y", i),    y_o[i],    exp_y(i));
            check($sformatf("u%0d_cur", i),  cur_o[i],  m_idx[i]);
            check($sformatf("u%0d_wrap", i), wrap_o[i], m_wrap[i]);
            check($sformatf("u%0d_onehot", i), ($countones(~y_o[i]) <= 1), 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; G1 = 1'b1; G2A_ = 1'b0; G2B_ = 1'b0;
        mode = 1'b0; load = 1'b0; addr = '0;
        for (int i = 0; i < 3; i++) begin
            m_idx[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0; m_en[i] = 0;
        end

        // Reset state
        step(); step();
        check("rst_y", y_o[0], 8'hFF);
        check("rst_cur", cur_o[0], 0);
        check("rst_wrap", wrap_o[0], 0);

        // Release in direct mode with enables active
        rst_n = 1'b1;
        step();
        check("rel_y", y_o[0], 8'hFE);
        check("rel_cur", cur_o[0], 0);

        // Direct load and enable gating
        load = 1'b1; addr = 3'd3;
        step();
        load = 1'b0;
        check("load3_y", y_o[0], 8'hF7);
        check("load3_cur", cur_o[0], 3);
        G1 = 1'b0; step();
        check("g1off_y", y_o[0], 8'hFF);
        check("g1off_cur", cur_o[0], 3);
        G1 = 1'b1; G2A_ = 1'b1; step();
        check("g2a_y", y_o[0], 8'hFF);
        G2A_ = 1'b0; G2B_ = 1'b1; step();
        check("g2b_y", y_o[0], 8'hFF);
        G2B_ = 1'b0; step();
        check("restore_y", y_o[0], 8'hF7);

        // Full scan cycle on u0 (DIV=4, LAST=7) from index 0
        load = 1'b1; addr = 3'd0; step();
        load = 1'b0; mode = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 4)  check("scan_k4_cur", cur_o[0], 1);
            if (k == 24) begin
                check("scan_k24_cur", cur_o[0], 6);
                check("scan_k24_y", y_o[0], 8'hBF);
            end
            if (k == 31) check("scan_k31_wrap", wrap_o[0], 0);
            if (k == 32) begin
                check("scan_k32_cur", cur_o[0], 0);
                check("scan_k32_wrap", wrap_o[0], 1);
            end
        end

        // Pause mid-dwell at prescaler 2
        step(); step();
        G1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pause_y", y_o[0], 8'hFF);
            check("pause_cur", cur_o[0], 0);
        end
        G1 = 1'b1;
        step();
        check("resume1_cur", cur_o[0], 0);
        step();
        check("resume2_cur", cur_o[0], 1);

        // Reach index 5 then reset mid-dwell
        for (int k = 0; k < 18; k++) step();
        check("pre_rst_cur", cur_o[0], 5);
        rst_n = 1'b0; step();
        check("midrst_y", y_o[0], 8'hFF);
        check("midrst_cur", cur_o[0], 0);
        check("midrst_wrap", wrap_o[0], 0);
        rst_n = 1'b1; mode = 1'b0;
        step();

        // u1 (DIV=1, LAST=5): out-of-range index folds back to 0
        load = 1'b1; addr = 3'd7; step();
        check("u1_load7", cur_o[1], 7);
        load = 1'b0; mode = 1'b1; step();
        check("u1_fold_cur", cur_o[1], 0);
        check("u1_fold_wrap", wrap_o[1], 1);
        for (int j = 1; j <= 6; j++) begin
            step();
            check("u1_cyc_cur", cur_o[1], j % 6);
            check("u1_cyc_wrap", wrap_o[1], (j == 6) ? 1 : 0);
        end
        load = 1'b1; addr = 3'd2; step();
        load = 1'b0;
        check("u1_load_ign", cur_o[1], 1);

        // u2 (DIV=3): direct to scan at index 4
        mode = 1'b0; load = 1'b1; addr = 3'd4; step();
        load = 1'b0; mode = 1'b1;
        step(); check("u2_hold1", cur_o[2], 4);
        step(); check("u2_hold2", cur_o[2], 4);
        step(); check("u2_adv", cur_o[2], 5);

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            G1    = ($urandom_range(0, 9) != 0);
            G2A_  = ($urandom_range(0, 11) == 0);
            G2B_  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load  = $urandom_range(0, 1);
            addr  = 3'($urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
